// File: rtl/fir_err_stats.sv
// Streaming error-statistics accumulator for paired approximate/accurate FIR outputs.
// Two register stages (difference/magnitudes, then square) feed the window accumulators.
//
// state | meaning
// IDLE  | waiting for start; results from the last window held
// RUN   | accepting pairs until N have been handshaken
// DRAIN | letting the pipeline empty into the accumulators
// DONE  | one cycle, results final, done asserted
module fir_err_stats #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 64,
  parameter int SQ_W   = 80
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_samples,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   appr,
  input  logic [DATA_W-1:0]   accu,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    err_sum,
  output logic [ACC_W-1:0]    abs_accu_sum,
  output logic [SQ_W-1:0]     err_sq_sum,
  output logic [DATA_W:0]     max_abs_err,
  output logic [CNT_W-1:0]    count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    accepted;
  logic                drain_first;
  logic                hs;

  logic [DATA_W:0]     err_c;
  logic [DATA_W:0]     abs_err_c;
  logic [DATA_W-1:0]   abs_accu_c;

  logic                v1;
  logic [DATA_W:0]     err1;
  logic [DATA_W:0]     abs_err1;
  logic [DATA_W-1:0]   abs_accu1;

  logic                v2;
  logic [DATA_W:0]     err2;
  logic [DATA_W:0]     abs_err2;
  logic [DATA_W-1:0]   abs_accu2;
  logic [2*DATA_W+1:0] sq2;

  logic [SQ_W:0]       sq_sum_c;

  // in_ready depends only on registered state, never on in_valid
  assign in_ready = (state == RUN) && (accepted < num_q);
  assign hs       = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Stage-1 arithmetic: one extra bit keeps the difference and both magnitudes exact
  always_comb begin
    err_c      = {appr[DATA_W-1], appr} - {accu[DATA_W-1], accu};
    abs_err_c  = err_c[DATA_W] ? -err_c : err_c;
    abs_accu_c = accu[DATA_W-1] ? -accu : accu;
    sq_sum_c   = {1'b0, err_sq_sum} + {{(SQ_W-2*DATA_W-1){1'b0}}, sq2};
  end

  // Pipeline datapath registers; qualified by v1/v2 so they need no reset
  always_ff @(posedge clk) begin
    err1      <= err_c;
    abs_err1  <= abs_err_c;
    abs_accu1 <= abs_accu_c;
    err2      <= err1;
    abs_err2  <= abs_err1;
    abs_accu2 <= abs_accu1;
    sq2       <= {{(DATA_W+1){1'b0}}, abs_err1} * {{(DATA_W+1){1'b0}}, abs_err1};
  end

  // Control FSM, pipe valids and window accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      num_q        <= '0;
      accepted     <= '0;
      drain_first  <= 1'b0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      err_sum      <= '0;
      abs_accu_sum <= '0;
      err_sq_sum   <= '0;
      max_abs_err  <= '0;
      count        <= '0;
    end else begin
      v1 <= hs;
      v2 <= v1;
      if (hs) accepted <= accepted + CNT_W'(1);
      if (v2) begin
        err_sum      <= err_sum + {{(ACC_W-DATA_W-1){err2[DATA_W]}}, err2};
        abs_accu_sum <= abs_accu_sum + {{(ACC_W-DATA_W){1'b0}}, abs_accu2};
        err_sq_sum   <= sq_sum_c[SQ_W] ? '1 : sq_sum_c[SQ_W-1:0];
        if (abs_err2 > max_abs_err) max_abs_err <= abs_err2;
        count        <= count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            num_q        <= num_samples;
            accepted     <= '0;
            err_sum      <= '0;
            abs_accu_sum <= '0;
            err_sq_sum   <= '0;
            max_abs_err  <= '0;
            count        <= '0;
            drain_first  <= 1'b1;
            state        <= (num_samples == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          drain_first <= 1'b1;
          if (hs && ((accepted + CNT_W'(1)) == num_q)) state <= DRAIN;
        end
        DRAIN: begin
          // the first DRAIN cycle never completes, so an empty window still spans two edges
          drain_first <= 1'b0;
          if (!drain_first && !v1 && !v2) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
